// File: rtl/mag_cook_controller.sv
// ---------------------------------------------------------------------------
// mag_cook_controller
//
// Sequencing controller for the magnetron path. Accepts keypad time entry,
// start/stop/clear buttons and the door interlock, counts the entered time
// down in BCD mm:ss while cooking, and holds an end-of-cook beep for a fixed
// number of seconds afterwards. All panel inputs arrive already synchronised.
//
// Parameters:
//   CYCLES_PER_SEC  clk cycles per countdown second
//   BEEP_SECS       seconds the beep stays asserted in DONE
//   QUICK_SECS      BCD seconds loaded by start with zero time in IDLE
//
// Ports:
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   startn       in   start button, active-low level
//   stopn        in   stop button, active-low level
//   clearn       in   clear button, active-low level
//   door_closed  in   1 = door closed
//   digit_valid  in   one-cycle keypad strobe
//   digit        in   keypad digit (BCD)
//   mag_on       out  magnetron enable
//   time_bcd     out  remaining/entered time {m1,m0,s1,s0}
//   state        out  0 IDLE, 1 SETUP, 2 COOK, 3 PAUSE, 4 DONE
//   beep         out  end-of-cook tone enable
// ---------------------------------------------------------------------------
module mag_cook_controller #(
    parameter int unsigned CYCLES_PER_SEC = 50000000,
    parameter int unsigned BEEP_SECS      = 3,
    parameter logic [7:0]  QUICK_SECS     = 8'h30
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        door_closed,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    output logic        mag_on,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        beep
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_COOK  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam int unsigned PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam int unsigned BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CYCLES_PER_SEC - 1);
    localparam logic [BW-1:0] BEEP_MAX  = BW'(BEEP_SECS - 1);

    state_e          state_q, state_d;
    logic [15:0]     time_q, time_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [BW-1:0]   beep_cnt_q, beep_cnt_d;
    logic            beep_q, beep_d;

    // Previous-cycle button levels; reset to released so a press needs a
    // genuine 1->0 edge.
    logic            startn_q, stopn_q, clearn_q;

    logic            start_p, stop_p, clear_p;
    logic            digit_ok;
    logic            tick;
    logic [PW-1:0]   presc_inc;
    logic [15:0]     time_dec;
    logic [15:0]     time_shift;

    // One BCD second down. Seconds above 59 are not corrected; they simply
    // count down digit-wise until they pass through 59 naturally.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
            s0 = 4'd9;
        end else begin
            s1 = 4'd5;
            s0 = 4'd9;
            if (m0 != 4'd0) begin
                m0 = m0 - 4'd1;
            end else begin
                m0 = 4'd9;
                m1 = m1 - 4'd1;
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    always_comb begin
        start_p    = startn_q & ~startn;
        stop_p     = stopn_q  & ~stopn;
        clear_p    = clearn_q & ~clearn;
        digit_ok   = digit_valid && (digit <= 4'd9);
        tick       = (presc_q == PRESC_MAX);
        presc_inc  = tick ? '0 : presc_q + PW'(1);
        time_dec   = bcd_dec(time_q);
        time_shift = {time_q[11:0], digit};

        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        beep_cnt_d = beep_cnt_q;
        beep_d     = beep_q;

        if (clear_p) begin
            state_d    = S_IDLE;
            time_d     = '0;
            presc_d    = '0;
            beep_d     = 1'b0;
            beep_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // A stop or start press consumes the cycle even when it
                    // has no effect, so a coincident digit is dropped.
                    if (stop_p) begin
                        state_d = S_IDLE;
                    end else if (start_p) begin
                        if (door_closed) begin
                            state_d = S_COOK;
                            presc_d = '0;
                            if (time_q == 16'h0000)
                                time_d = {8'h00, QUICK_SECS};
                        end
                    end else if (digit_ok) begin
                        time_d  = time_shift;
                        state_d = S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (stop_p) begin
                        state_d = S_IDLE;
                        time_d  = '0;
                        presc_d = '0;
                    end else if (start_p) begin
                        if (door_closed && (time_q != 16'h0000)) begin
                            state_d = S_COOK;
                            presc_d = '0;
                        end
                    end else if (digit_ok) begin
                        time_d = time_shift;
                    end
                end

                S_COOK: begin
                    // Prescaler is frozen on the way out so PAUSE keeps the
                    // partial second.
                    if (stop_p || !door_closed) begin
                        state_d = S_PAUSE;
                    end else begin
                        presc_d = presc_inc;
                        if (tick) begin
                            time_d = time_dec;
                            if (time_dec == 16'h0000) begin
                                state_d    = S_DONE;
                                presc_d    = '0;
                                beep_d     = 1'b1;
                                beep_cnt_d = '0;
                            end
                        end
                    end
                end

                S_PAUSE: begin
                    if (stop_p) begin
                        state_d = S_IDLE;
                        time_d  = '0;
                        presc_d = '0;
                    end else if (start_p && door_closed) begin
                        state_d = S_COOK;
                    end
                end

                S_DONE: begin
                    if (stop_p || start_p) begin
                        state_d    = S_IDLE;
                        presc_d    = '0;
                        beep_d     = 1'b0;
                        beep_cnt_d = '0;
                    end else begin
                        presc_d = presc_inc;
                        if (tick) begin
                            if (beep_cnt_q == BEEP_MAX) begin
                                state_d    = S_IDLE;
                                beep_d     = 1'b0;
                                beep_cnt_d = '0;
                            end else begin
                                beep_cnt_d = beep_cnt_q + BW'(1);
                            end
                        end
                    end
                end

                default: begin
                    state_d    = S_IDLE;
                    time_d     = '0;
                    presc_d    = '0;
                    beep_d     = 1'b0;
                    beep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            time_q     <= '0;
            presc_q    <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
            startn_q   <= 1'b1;
            stopn_q    <= 1'b1;
            clearn_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            beep_cnt_q <= beep_cnt_d;
            beep_q     <= beep_d;
            startn_q   <= startn;
            stopn_q    <= stopn;
            clearn_q   <= clearn;
        end
    end

    // Door gating is combinational so the magnetron drops in the same cycle
    // the door opens, ahead of the registered move to PAUSE.
    assign mag_on   = (state_q == S_COOK) & door_closed;
    assign time_bcd = time_q;
    assign state    = state_q;
    assign beep     = beep_q;

endmodule

// File: tb/tb_mag_cook_controller.sv
module tb_mag_cook_controller;

    logic        clk;
    logic        resetn;
    logic        startn;
    logic        stopn;
    logic        clearn;
    logic        door_closed;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        mag_on;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        beep;

    int checks = 0;
    int errors = 0;

    mag_cook_controller #(
        .CYCLES_PER_SEC(4),
        .BEEP_SECS     (3),
        .QUICK_SECS    (8'h30)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .startn     (startn),
        .stopn      (stopn),
        .clearn     (clearn),
        .door_closed(door_closed),
        .digit_valid(digit_valid),
        .digit      (digit),
        .mag_on     (mag_on),
        .time_bcd   (time_bcd),
        .state      (state),
        .beep       (beep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        startn;
        logic        stopn;
        logic        clearn;
        logic        door;
        logic        dv;
        logic [3:0]  digit;
        int          cycles;
        logic [2:0]  st;
        logic [15:0] tm;
        logic        mag;
        logic        bp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic p, input logic c,
                                input logic d, input logic dv, input logic [3:0] dg,
                                input int n, input logic [2:0] st,
                                input logic [15:0] tm, input logic mag, input logic bp);
        vec_t v;
        v.startn = s;  v.stopn = p;  v.clearn = c;  v.door = d;
        v.dv = dv;     v.digit = dg; v.cycles = n;
        v.st = st;     v.tm = tm;    v.mag = mag;   v.bp = bp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [15:0] tm,
                           input logic mag, input logic bp);
        chk({tag, ".state"},  16'(state),  16'(st));
        chk({tag, ".time"},   time_bcd,    tm);
        chk({tag, ".mag_on"}, 16'(mag_on), 16'(mag));
        chk({tag, ".beep"},   16'(beep),   16'(bp));
    endtask

    // Drive one cycle of inputs, clock once, sample after the edge.
    task automatic drive(input logic s, input logic p, input logic c,
                         input logic d, input logic dv, input logic [3:0] dg);
        startn = s; stopn = p; clearn = c; door_closed = d;
        digit_valid = dv; digit = dg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // state codes: 0 IDLE 1 SETUP 2 COOK 3 PAUSE 4 DONE
        // 1:05 entry with a rejected digit, then countdown
        vecs.push_back(mk(1,1,1,1,1,4'h1, 1, 1,16'h0001,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h0, 1, 1,16'h0010,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h5, 1, 1,16'h0105,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'hA, 1, 1,16'h0105,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0105,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 3, 2,16'h0105,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 2,16'h0104,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0,16, 2,16'h0100,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 4, 2,16'h0059,1,0));
        // stop -> PAUSE, stop again -> IDLE cleared
        vecs.push_back(mk(1,0,1,1,0,4'h0, 1, 3,16'h0059,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 3,16'h0059,0,0));
        vecs.push_back(mk(1,0,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        // quick start with start held for 10 cycles
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0030,1,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 9, 2,16'h0028,1,0));
        vecs.push_back(mk(1,0,1,1,0,4'h0, 1, 3,16'h0028,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 3,16'h0028,0,0));
        vecs.push_back(mk(1,0,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        // start and clear together in SETUP
        vecs.push_back(mk(1,1,1,1,1,4'h1, 1, 1,16'h0001,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h2, 1, 1,16'h0012,0,0));
        vecs.push_back(mk(0,1,0,1,0,4'h0, 1, 0,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        // start with door open ignored; door opens 2 clk into a second
        vecs.push_back(mk(1,1,1,1,1,4'h7, 1, 1,16'h0007,0,0));
        vecs.push_back(mk(0,1,1,0,0,4'h0, 1, 1,16'h0007,0,0));
        vecs.push_back(mk(1,1,1,0,0,4'h0, 1, 1,16'h0007,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0007,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 2, 2,16'h0007,1,0));
        vecs.push_back(mk(1,1,1,0,0,4'h0, 1, 3,16'h0007,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 3,16'h0007,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0007,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 2,16'h0007,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 2,16'h0006,1,0));
        // run out to DONE, 12-cycle beep
        vecs.push_back(mk(1,1,0,1,0,4'h0, 1, 0,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h2, 1, 1,16'h0002,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0002,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 4, 2,16'h0001,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 3, 2,16'h0001,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 4,16'h0000,0,1));
        vecs.push_back(mk(1,1,1,1,0,4'h0,11, 4,16'h0000,0,1));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        // button press ends DONE early
        vecs.push_back(mk(1,1,1,1,1,4'h1, 1, 1,16'h0001,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0001,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 4, 4,16'h0000,0,1));
        vecs.push_back(mk(1,0,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 1, 0,16'h0000,0,0));
        // 0:90 counts down without correction
        vecs.push_back(mk(1,1,1,1,1,4'h9, 1, 1,16'h0009,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h0, 1, 1,16'h0090,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h0090,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 4, 2,16'h0089,1,0));
        // 10:00 borrows from the tens of minutes; digits ignored in COOK
        vecs.push_back(mk(1,1,0,1,0,4'h0, 1, 0,16'h0000,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h1, 1, 1,16'h0001,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h0, 1, 1,16'h0010,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h0, 1, 1,16'h0100,0,0));
        vecs.push_back(mk(1,1,1,1,1,4'h0, 1, 1,16'h1000,0,0));
        vecs.push_back(mk(0,1,1,1,0,4'h0, 1, 2,16'h1000,1,0));
        vecs.push_back(mk(1,1,1,1,0,4'h0, 4, 2,16'h0959,1,0));
        vecs.push_back(mk(1,1,1,1,1,4'h3, 1, 2,16'h0959,1,0));

        // reset
        resetn = 1'b0;
        startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
        door_closed = 1'b1; digit_valid = 1'b0; digit = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 16'h0000, 1'b0, 1'b0);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            startn = vecs[i].startn; stopn = vecs[i].stopn; clearn = vecs[i].clearn;
            door_closed = vecs[i].door; digit_valid = vecs[i].dv; digit = vecs[i].digit;
            repeat (vecs[i].cycles) @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tm, vecs[i].mag, vecs[i].bp);
        end

        // reset asserted mid-COOK: outputs drop without a clock edge
        digit_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk_all("midreset", 3'd0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk_all("postreset", 3'd0, 16'h0000, 1'b0, 1'b0);

        // door opening drops mag_on combinationally before the state moves
        drive(1,1,1,1,1,4'h3);
        drive(0,1,1,1,0,4'h0);
        drive(1,1,1,1,0,4'h0);
        chk_all("doorpre", 3'd2, 16'h0003, 1'b1, 1'b0);
        door_closed = 1'b0;
        #1;
        chk("doorcomb.mag_on", 16'(mag_on), 16'h0000);
        chk("doorcomb.state",  16'(state),  16'h0002);
        @(posedge clk);
        #1;
        chk_all("doorpause", 3'd3, 16'h0003, 1'b0, 1'b0);
        drive(1,1,1,1,1,4'h5);
        chk_all("pausedigit", 3'd3, 16'h0003, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mag_cook_controller.md
Name: mag_cook_controller

Overview:
- Sequencing controller for the magnetron path: handles keypad time entry, start/stop/clear buttons, door interlock, BCD mm:ss countdown and end-of-cook beep.
- Drives the magnetron enable directly and replaces the bare set/reset latch control with a full state machine.
- Sits between the front-panel inputs and the magnetron power stage. All panel inputs are already synchronised upstream.

Parameters:
- CYCLES_PER_SEC, 50000000, clk cycles per countdown second (benches use 4).
- BEEP_SECS, 3, seconds beep stays asserted in DONE.
- QUICK_SECS, 8'h30, BCD seconds loaded when start is pressed with zero time in IDLE.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- startn  in  1  start button, active-low level.
- stopn  in  1  stop button, active-low level.
- clearn  in  1  clear button, active-low level.
- door_closed  in  1  1 = door closed.
- digit_valid  in  1  one-cycle strobe, keypad digit present.
- digit  in  4  keypad digit, BCD.
- mag_on  out  1  magnetron enable.
- time_bcd  out  16  remaining/entered time {m1,m0,s1,s0}, BCD.
- state  out  3  0 IDLE, 1 SETUP, 2 COOK, 3 PAUSE, 4 DONE.
- beep  out  1  end-of-cook tone enable.

Behaviour:
- Reset (async, resetn=0): state=IDLE, time_bcd=0, mag_on=0, beep=0, prescaler=0, button history regs=1 (released), so no press is detected on the first edge after reset.
- Press detection: a press is a 1->0 transition of startn/stopn/clearn vs. the previous-cycle value, giving a one-cycle internal pulse. A held button acts once.
- Priority when pulses coincide: clear > stop > door open > start > digit.
- Clear (any state): -> IDLE, time_bcd=0, prescaler=0, beep=0.
- IDLE:
  - digit_valid with digit<=9 -> time_bcd = {time_bcd[11:0],digit}, go to SETUP.
  - start with door_closed: time=0 loads 16'h00 & QUICK_SECS, otherwise keeps time; -> COOK.
- SETUP:
  - digit shifts in as above; the oldest digit is discarded.
  - digit>9 is ignored in every state.
  - start with door_closed and time!=0 -> COOK. Start with time=0 or door open is ignored.
  - stop -> IDLE, time cleared.
- COOK:
  - The prescaler counts 0..CYCLES_PER_SEC-1. At wrap, time decrements by one BCD second:
    - s0 borrows from s1.
    - s1:s0=00 borrows a minute and sets seconds to 59.
    - minutes borrow m0 from m1.
  - Seconds entered above 59 (e.g. 0:90) count down 90..60,59.. without correction.
  - Decrement reaching 0000 -> DONE, prescaler=0.
  - stop -> PAUSE. door_closed=0 -> PAUSE.
  - Digits are ignored.
- PAUSE:
  - The prescaler holds its value, so a partial second is preserved.
  - start with door_closed -> COOK.
  - stop -> IDLE, time cleared.
  - Digits are ignored.
- DONE:
  - beep=1. The prescaler runs. After BEEP_SECS wraps -> IDLE, beep=0.
  - Any button press -> IDLE immediately.
- mag_on = cook_reg & door_closed, where cook_reg is the registered (state==COOK).
  - The door-open gating is combinational, so mag_on falls in the same cycle door_closed falls, independent of the state update.
  - mag_on is 0 in every state other than COOK.
- Outputs time_bcd, state and beep are registered. State changes take effect one clk after the qualifying input is sampled.
- Prescaler is cleared on every transition into COOK from IDLE/SETUP and on entry to IDLE and DONE. It is not cleared on PAUSE->COOK.
- Reset asserted mid-cook: mag_on drops asynchronously with the registers. No other state is retained.

Test Plan (CYCLES_PER_SEC=4, BEEP_SECS=3):
- Reset, digits 1,0,5, start, door closed -> time_bcd 0x0105 and state COOK. After 4 clk time is 0x0104. After 24 clk it crosses 0x0100 -> 0x0059. mag_on=1 throughout.
- Time 0x0002 in COOK -> 0x0001, then 0x0000 and state DONE. beep=1 for 12 clk, then IDLE and beep=0. mag_on falls on the DONE transition.
- Door opens 2 clk into a second while cooking -> mag_on=0 in the same cycle and state PAUSE. Door closes, start -> COOK; next decrement comes after 2 clk, not 4.
- Start held low for 10 clk in IDLE with time 0 -> single load of 0x0030 and COOK. Stop -> PAUSE. Stop again -> IDLE with time 0x0000.
- Same cycle start+clear falling in SETUP with time 0x0012 -> IDLE, time 0x0000, mag_on stays 0. Digit 0xA in SETUP -> time unchanged.
- Start with door open in SETUP -> no transition, mag_on=0. resetn pulsed low mid-COOK -> all outputs 0 immediately, IDLE after release.
